// File: rtl/id_inst_queue_if.sv
// IF/ID instruction-queue bundle: fetch request, SRAM return data, ID-side head handshake.
// The queue connects through the slave modport; the IF/ID side connects through master.
interface id_inst_queue_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = 3
);
  logic              flush;
  logic              req_valid;
  logic [PC_W-1:0]   req_pc;
  logic              req_ready;
  logic [INST_W-1:0] inst_sram_rdata;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, req_valid, req_pc, inst_sram_rdata, out_ready,
    input  req_ready, out_valid, out_pc, out_inst, count
  );

  modport slave (
    input  flush, req_valid, req_pc, inst_sram_rdata, out_ready,
    output req_ready, out_valid, out_pc, out_inst, count
  );
endinterface

// File: rtl/id_inst_queue.sv
// IF->ID instruction queue: tracks fetch requests, captures 1-cycle SRAM returns into a
// DEPTH-entry {pc, inst} FIFO, and discards everything queued or in flight on flush.
module id_inst_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            resetn,
  id_inst_queue_if.slave  q
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];

  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             resp_v_q, resp_v_d;
  logic [PC_W-1:0]  resp_pc_q, resp_pc_d;

  logic             req_ready;
  logic             accept;
  logic             push;
  logic             pop;
  logic [CNT_W:0]   reserved;

  // The in-flight response holds a slot; a same-cycle pop earns no credit.
  assign reserved  = {1'b0, count_q} + {{CNT_W{1'b0}}, resp_v_q};
  assign req_ready = !q.flush && (reserved < (CNT_W+1)'(DEPTH));
  assign accept    = q.req_valid && req_ready;
  assign push      = resp_v_q && !q.flush;
  assign pop       = (count_q != '0) && q.out_ready && !q.flush;

  assign q.req_ready = req_ready;
  assign q.out_valid = (count_q != '0);
  assign q.out_pc    = pc_q[rptr_q];
  assign q.out_inst  = inst_q[rptr_q];
  assign q.count     = count_q;

  always_comb begin
    rptr_d    = rptr_q;
    wptr_d    = wptr_q;
    count_d   = count_q;
    resp_v_d  = accept;
    resp_pc_d = resp_pc_q;
    if (accept) begin
      resp_pc_d = q.req_pc;
    end
    if (q.flush) begin
      rptr_d   = '0;
      wptr_d   = '0;
      count_d  = '0;
      resp_v_d = 1'b0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      resp_v_q  <= 1'b0;
      resp_pc_q <= '0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      resp_v_q  <= resp_v_d;
      resp_pc_q <= resp_pc_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q   <= '{default: '0};
      inst_q <= '{default: '0};
    end else if (push) begin
      pc_q[wptr_q]   <= resp_pc_q;
      inst_q[wptr_q] <= q.inst_sram_rdata;
    end
  end
endmodule

// File: tb/tb_id_inst_queue.sv
// Directed bench for id_inst_queue: a queue-level reference model checked every cycle,
// plus hand-computed expectations for reset, streaming, backpressure, flush and wrap.
module tb_id_inst_queue;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  id_inst_queue_if #(.PC_W(32), .INST_W(32), .CNT_W(3)) qif ();

  id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .q      (qif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, inst} plus one in-flight request slot.
  logic [63:0] mq[$];
  logic        mv;
  logic [31:0] mpc;
  logic [31:0] seen[$];

  initial begin
    mv  = 1'b0;
    mpc = '0;
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      mv  = 1'b0;
      mpc = '0;
    end else if (qif.flush) begin
      mq.delete();
      mv = 1'b0;
    end else begin
      logic acc;
      acc = qif.req_valid && ((mq.size() + int'(mv)) < DEPTH);
      if (mq.size() != 0 && qif.out_ready) void'(mq.pop_front());
      if (mv) mq.push_back({mpc, qif.inst_sram_rdata});
      mv  = acc;
      mpc = qif.req_pc;
    end
  end

  always @(negedge clk) begin
    logic exp_v;
    exp_v = (mq.size() != 0);
    chk("out_valid", qif.out_valid, exp_v);
    chk("count", qif.count, mq.size());
    chk("req_ready", qif.req_ready, !qif.flush && ((mq.size() + int'(mv)) < DEPTH));
    if (exp_v) begin
      chk("out_pc", qif.out_pc, mq[0][63:32]);
      chk("out_inst", qif.out_inst, mq[0][31:0]);
    end
    if (qif.out_valid && qif.out_ready && !qif.flush) seen.push_back(qif.out_pc);
  end

  logic [31:0] last_pc;

  // SRAM stand-in: returns ~pc of the previous cycle's request, accepted or not.
  task automatic set_in(input logic fl, input logic rv, input logic [31:0] pc, input logic ordy);
    qif.flush           = fl;
    qif.req_valid       = rv;
    qif.req_pc          = pc;
    qif.out_ready       = ordy;
    qif.inst_sram_rdata = last_pc ^ 32'hffffffff;
    last_pc             = pc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic fl, input logic rv, input logic [31:0] pc, input logic ordy);
    set_in(fl, rv, pc, ordy);
    step();
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    last_pc = '0;
    resetn  = 1'b0;
    set_in(0, 0, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("rst_out_valid", qif.out_valid, 1'b0);
    chk("rst_out_pc", qif.out_pc, 32'h0);
    chk("rst_out_inst", qif.out_inst, 32'h0);
    chk("rst_count", qif.count, 3'd0);
    chk("rst_req_ready", qif.req_ready, 1'b1);

    // Fill 3 entries, then assert reset between edges.
    tick(0, 1, 32'h10, 0);
    tick(0, 1, 32'h14, 0);
    tick(0, 1, 32'h18, 0);
    tick(0, 0, 32'h0, 0);
    chk("fill3_count", qif.count, 3'd3);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_out_valid", qif.out_valid, 1'b0);
    chk("async_count", qif.count, 3'd0);
    chk("async_req_ready", qif.req_ready, 1'b1);
    step();
    resetn = 1'b1;
    tick(0, 1, 32'hbfc00000, 0);
    tick(0, 0, 32'h0, 0);
    chk("first_out_valid", qif.out_valid, 1'b1);
    chk("first_out_pc", qif.out_pc, 32'hbfc00000);
    chk("first_out_inst", qif.out_inst, 32'h403fffff);
    tick(0, 0, 32'h0, 1);

    // Streaming with out_ready held high.
    for (int k = 0; k < 8; k++) begin
      tick(0, 1, 32'hbfc00000 + 32'(4 * k), 1);
      if (k == 2) begin
        chk("stream_count", qif.count, 3'd1);
        chk("stream_pc", qif.out_pc, 32'hbfc00004);
      end
    end
    repeat (3) tick(0, 0, 32'h0, 1);

    // Backpressure: only DEPTH requests fit.
    for (int i = 0; i < 6; i++) tick(0, 1, 32'h1000 + 32'(4 * i), 0);
    chk("bp_count", qif.count, 3'd4);
    chk("bp_req_ready", qif.req_ready, 1'b0);
    tick(0, 1, 32'h2000, 1);
    chk("bp_ready_after_pop", qif.req_ready, 1'b1);
    chk("bp_head_after_pop", qif.out_pc, 32'h1004);
    repeat (6) tick(0, 0, 32'h0, 1);

    // Flush with 2 queued and one in flight.
    tick(0, 1, 32'h50, 0);
    tick(0, 1, 32'h54, 0);
    tick(0, 1, 32'h100, 0);
    tick(1, 0, 32'h0, 0);
    chk("flush_count", qif.count, 3'd0);
    chk("flush_out_valid", qif.out_valid, 1'b0);
    tick(0, 1, 32'h200, 1);
    tick(0, 0, 32'h0, 1);
    chk("post_flush_valid", qif.out_valid, 1'b1);
    chk("post_flush_pc", qif.out_pc, 32'h200);
    repeat (2) tick(0, 0, 32'h0, 1);

    // Wrap: 10 instructions, alternating out_ready.
    seen.delete();
    for (int i = 0; i < 20; i++) begin
      tick(0, (i % 2) == 0, 32'h3000 + 32'(4 * (i / 2)), (i % 2) == 1);
    end
    repeat (4) tick(0, 0, 32'h0, 1);
    chk("wrap_seen_n", seen.size(), 10);
    for (int i = 0; i < 10; i++) begin
      chk("wrap_pc", (i < seen.size()) ? seen[i] : 32'hdeadbeef, 32'h3000 + 32'(4 * i));
    end

    // Flush precedence over accept, push and pop in the same cycle.
    tick(0, 1, 32'h400, 0);
    tick(0, 1, 32'h404, 0);
    chk("prec_pre_count", qif.count, 3'd1);
    set_in(1, 1, 32'h408, 1);
    #1;
    chk("prec_req_ready", qif.req_ready, 1'b0);
    step();
    chk("prec_count", qif.count, 3'd0);
    chk("prec_out_valid", qif.out_valid, 1'b0);
    tick(0, 0, 32'h0, 1);
    tick(0, 0, 32'h0, 1);
    chk("prec_late_valid", qif.out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
